// File: rtl/multicycle_core_if.sv
// Memory-side handshake bundle for multicycle_core: instruction fetch port and data port.
// The instance's XLEN must match the core's XLEN.
interface multicycle_core_if #(
    parameter int XLEN = 64
);
    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [XLEN-1:0]     imem_addr;
    logic                imem_resp_valid;
    logic [31:0]         imem_resp_data;

    logic                dmem_req_valid;
    logic                dmem_req_ready;
    logic [XLEN-1:0]     dmem_req_addr;
    logic                dmem_req_wen;
    logic [XLEN-1:0]     dmem_req_wdata;
    logic [XLEN/8-1:0]   dmem_req_wmask;
    logic                dmem_resp_valid;
    logic [XLEN-1:0]     dmem_resp_rdata;

    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output dmem_req_valid, dmem_req_addr, dmem_req_wen, dmem_req_wdata, dmem_req_wmask,
        input  dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
    );

    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  dmem_req_valid, dmem_req_addr, dmem_req_wen, dmem_req_wdata, dmem_req_wmask,
        output dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
    );
endinterface

// File: rtl/multicycle_core.sv
// Multi-cycle RV32/RV64 (I/E) subset core sequencing FETCH/IWAIT/EXEC/MEM/DWAIT/WB over valid/ready memories.
// Optional cycle/instret counters are built when MULTICYCLE_CORE_PERF_CNT_EN is defined.
module multicycle_core #(
    parameter int          XLEN     = 64,
    parameter int          NUM_REGS = 32,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_core_if.master   mem,
    output logic [XLEN-1:0]     current_pc,
    output logic                retire,
    output logic                halted,
    output logic                illegal,
    output logic [63:0]         cycle_cnt,
    output logic [63:0]         instret_cnt
);
    localparam int          IDX_W    = $clog2(NUM_REGS);
    localparam logic [6:0]  OP_LUI   = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC = 7'b0010111;
    localparam logic [6:0]  OP_JAL   = 7'b1101111;
    localparam logic [6:0]  OP_JALR  = 7'b1100111;
    localparam logic [6:0]  OP_IMM   = 7'b0010011;
    localparam logic [6:0]  OP_REG   = 7'b0110011;
    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam logic [6:0]  OP_SYS   = 7'b1110011;
    localparam logic [2:0]  F3_FULL  = (XLEN == 64) ? 3'b011 : 3'b010;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;

    typedef enum logic [2:0] {
        S_FETCH, S_IWAIT, S_EXEC, S_MEM, S_DWAIT, S_WB, S_HALT, S_TRAP
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, npc_q, npc_d, wb_val_q, wb_val_d;
    logic [XLEN-1:0] maddr_q, maddr_d, mwdata_q, mwdata_d;
    logic [31:0]     ir_q, ir_d;
    logic            mwen_q, mwen_d, wb_en_q, wb_en_d;
    logic            retire_q, retire_d, halted_q, halted_d, illegal_q, illegal_d;
    logic [XLEN-1:0] rf_q [NUM_REGS];

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rd, rs1, rs2;
    logic signed [XLEN-1:0] imm_i, imm_s, imm_u, imm_j;
    logic [XLEN-1:0] rs1_val, rs2_val, pc_plus4, jalr_sum;
    logic [XLEN-1:0] dec_val, dec_npc, dec_addr;
    logic            dec_legal, dec_ebreak, dec_mem, dec_store, dec_wen;
    logic            use_rs1, use_rs2, bad_idx;

    // Immediates are placed at the top of the word and arithmetically shifted down to sign-extend.
    always_comb begin
        opcode   = ir_q[6:0];
        rd       = ir_q[11:7];
        funct3   = ir_q[14:12];
        rs1      = ir_q[19:15];
        rs2      = ir_q[24:20];
        funct7   = ir_q[31:25];
        imm_i    = $signed({ir_q[31:20], {(XLEN-12){1'b0}}}) >>> (XLEN - 12);
        imm_s    = $signed({ir_q[31:25], ir_q[11:7], {(XLEN-12){1'b0}}}) >>> (XLEN - 12);
        imm_u    = $signed({ir_q[31:12], {(XLEN-20){1'b0}}}) >>> (XLEN - 32);
        imm_j    = $signed({ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], {(XLEN-20){1'b0}}}) >>> (XLEN - 21);
        rs1_val  = '0;
        rs2_val  = '0;
        if (rs1 != 5'd0 && int'(rs1) < NUM_REGS) rs1_val = rf_q[rs1[IDX_W-1:0]];
        if (rs2 != 5'd0 && int'(rs2) < NUM_REGS) rs2_val = rf_q[rs2[IDX_W-1:0]];
        pc_plus4 = pc_q + XLEN'(4);
        jalr_sum = rs1_val + imm_i;
    end

    always_comb begin
        dec_legal  = 1'b0;
        dec_ebreak = 1'b0;
        dec_mem    = 1'b0;
        dec_store  = 1'b0;
        dec_wen    = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        dec_val    = '0;
        dec_npc    = pc_plus4;
        dec_addr   = rs1_val + imm_i;
        case (opcode)
            OP_LUI:   begin dec_legal = 1'b1; dec_wen = 1'b1; dec_val = imm_u; end
            OP_AUIPC: begin dec_legal = 1'b1; dec_wen = 1'b1; dec_val = pc_q + imm_u; end
            OP_JAL: begin
                dec_legal = 1'b1; dec_wen = 1'b1; dec_val = pc_plus4; dec_npc = pc_q + imm_j;
            end
            OP_JALR: if (funct3 == 3'b000) begin
                dec_legal = 1'b1; dec_wen = 1'b1; use_rs1 = 1'b1;
                dec_val   = pc_plus4;
                dec_npc   = {jalr_sum[XLEN-1:1], 1'b0};
            end
            OP_IMM: if (funct3 == 3'b000) begin
                dec_legal = 1'b1; dec_wen = 1'b1; use_rs1 = 1'b1; dec_val = rs1_val + imm_i;
            end
            OP_REG: if (funct3 == 3'b000) begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; dec_wen = 1'b1;
                if (funct7 == 7'b0000000) begin dec_legal = 1'b1; dec_val = rs1_val + rs2_val; end
                if (funct7 == 7'b0100000) begin dec_legal = 1'b1; dec_val = rs1_val - rs2_val; end
            end
            OP_LOAD: if (funct3 == F3_FULL) begin
                dec_legal = 1'b1; dec_wen = 1'b1; use_rs1 = 1'b1; dec_mem = 1'b1;
            end
            OP_STORE: if (funct3 == F3_FULL) begin
                dec_legal = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; dec_mem = 1'b1; dec_store = 1'b1;
                dec_addr  = rs1_val + imm_s;
            end
            OP_SYS: if (ir_q == EBREAK) begin dec_legal = 1'b1; dec_ebreak = 1'b1; end
            default: ;
        endcase
        bad_idx = (dec_wen && int'(rd) >= NUM_REGS) ||
                  (use_rs1 && int'(rs1) >= NUM_REGS) ||
                  (use_rs2 && int'(rs2) >= NUM_REGS);
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        npc_d    = npc_q;
        wb_val_d = wb_val_q;
        wb_en_d  = wb_en_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        mwen_d   = mwen_q;
        case (state_q)
            S_FETCH: if (mem.imem_req_ready) state_d = S_IWAIT;
            S_IWAIT: if (mem.imem_resp_valid) begin
                ir_d    = mem.imem_resp_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                npc_d    = dec_npc;
                wb_val_d = dec_val;
                wb_en_d  = dec_wen;
                maddr_d  = dec_addr;
                mwdata_d = rs2_val;
                mwen_d   = dec_store;
                if (!dec_legal || bad_idx) state_d = S_TRAP;
                else if (dec_ebreak)       state_d = S_HALT;
                else if (dec_mem)          state_d = S_MEM;
                else                       state_d = S_WB;
            end
            S_MEM: if (mem.dmem_req_ready) state_d = mwen_q ? S_WB : S_DWAIT;
            S_DWAIT: if (mem.dmem_resp_valid) begin
                wb_val_d = mem.dmem_resp_rdata;
                state_d  = S_WB;
            end
            S_WB: begin
                pc_d    = npc_q;
                state_d = S_FETCH;
            end
            default: ;
        endcase
        // EBREAK retires in the cycle it enters HALT; TRAP never retires.
        retire_d  = (state_d == S_WB) || (state_q == S_EXEC && state_d == S_HALT);
        halted_d  = halted_q  || (state_d == S_HALT);
        illegal_d = illegal_q || (state_d == S_TRAP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC[XLEN-1:0];
            retire_q  <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retire_q  <= retire_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            if (state_q == S_WB && wb_en_q && rd != 5'd0) rf_q[rd[IDX_W-1:0]] <= wb_val_q;
        end
        ir_q     <= ir_d;
        npc_q    <= npc_d;
        wb_val_q <= wb_val_d;
        wb_en_q  <= wb_en_d;
        maddr_q  <= maddr_d;
        mwdata_q <= mwdata_d;
        mwen_q   <= mwen_d;
        rf_q[0]  <= '0;
    end

    assign mem.imem_req_valid = (state_q == S_FETCH) && !rst;
    assign mem.imem_addr      = pc_q;
    assign mem.dmem_req_valid = (state_q == S_MEM) && !rst;
    assign mem.dmem_req_addr  = maddr_q;
    assign mem.dmem_req_wen   = mwen_q;
    assign mem.dmem_req_wdata = mwdata_q;
    assign mem.dmem_req_wmask = '1;
    assign current_pc         = pc_q;
    assign retire             = retire_q;
    assign halted             = halted_q;
    assign illegal            = illegal_q;

`ifdef MULTICYCLE_CORE_PERF_CNT_EN
    logic [63:0] cyc_q, cyc_d, inst_q, inst_d;
    logic        stop_q, stop_d;

    // stop_q lags the sticky flags so the cycle that raises halted/illegal is still counted.
    always_comb begin
        stop_d = halted_q || illegal_q;
        cyc_d  = stop_q ? cyc_q : cyc_q + 64'd1;
        inst_d = inst_q + {63'd0, retire_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stop_q <= 1'b0;
            cyc_q  <= '0;
            inst_q <= '0;
        end else begin
            stop_q <= stop_d;
            cyc_q  <= cyc_d;
            inst_q <= inst_d;
        end
    end

    assign cycle_cnt   = cyc_q;
    assign instret_cnt = inst_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif
endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core with a negedge-driven instruction/data memory responder.
module tb_multicycle_core;
    localparam int          XLEN   = 64;
    localparam logic [63:0] RPC    = 64'h8000_0000;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_core_if #(.XLEN(XLEN)) mif ();

    logic [XLEN-1:0] current_pc;
    logic            retire, halted, illegal;
    logic [63:0]     cycle_cnt, instret_cnt;

    multicycle_core #(.XLEN(XLEN), .NUM_REGS(32), .RESET_PC(RPC)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem         (mif),
        .current_pc  (current_pc),
        .retire      (retire),
        .halted      (halted),
        .illegal     (illegal),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    logic [31:0] imem [16];
    logic [63:0] dmem [32];
    int          dmem_delay = 1;
    int          d_cnt = 0;
    logic        i_pend = 1'b0;
    logic [31:0] i_data;
    logic [63:0] ld_addr;
    logic [63:0] st_addr, st_wdata;
    logic [7:0]  st_mask;
    int          st_n = 0;
    logic [63:0] fetch_log [8];
    int          fetch_n = 0;
    int          retire_n = 0;
    int          req_when_stopped = 0;

    int n_checks = 0;
    int n_errors = 0;

    // Memory responder: a handshake seen at a negedge completes at the next posedge; data follows later.
    always @(negedge clk) begin
        mif.imem_resp_valid = 1'b0;
        mif.dmem_resp_valid = 1'b0;
        if (rst) begin
            i_pend = 1'b0;
            d_cnt = 0;
            st_n = 0;
            fetch_n = 0;
            retire_n = 0;
            req_when_stopped = 0;
        end else begin
            if (i_pend) begin
                mif.imem_resp_valid = 1'b1;
                mif.imem_resp_data  = i_data;
                i_pend = 1'b0;
            end
            if (mif.imem_req_valid && mif.imem_req_ready) begin
                i_data = imem[mif.imem_addr[5:2]];
                i_pend = 1'b1;
                if (fetch_n < 8) fetch_log[fetch_n] = mif.imem_addr;
                fetch_n++;
            end
            if (d_cnt > 0) begin
                d_cnt--;
                if (d_cnt == 0) begin
                    mif.dmem_resp_valid = 1'b1;
                    mif.dmem_resp_rdata = dmem[ld_addr[7:3]];
                end
            end
            if (mif.dmem_req_valid && mif.dmem_req_ready) begin
                if (mif.dmem_req_wen) begin
                    dmem[mif.dmem_req_addr[7:3]] = mif.dmem_req_wdata;
                    st_addr  = mif.dmem_req_addr;
                    st_wdata = mif.dmem_req_wdata;
                    st_mask  = mif.dmem_req_wmask;
                    st_n++;
                end else begin
                    ld_addr = mif.dmem_req_addr;
                    d_cnt   = dmem_delay;
                end
            end
            if (retire) retire_n++;
            if ((halted || illegal) && mif.imem_req_valid) req_when_stopped++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_imem();
        foreach (imem[i]) imem[i] = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_stop(input int bound, output int edges);
        edges = 0;
        while (!(halted || illegal) && edges < bound) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("stop_reached", {63'd0, halted || illegal}, 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int edges;

    initial begin
        // Reset state, then addi x1,x0,5 ; add x2,x1,x1 ; ebreak
        rst = 1'b1;
        mif.imem_req_ready = 1'b1;
        mif.dmem_req_ready = 1'b1;
        clear_imem();
        imem[0] = 32'h0050_0093;
        imem[1] = 32'h0010_8133;
        imem[2] = EBREAK;
        repeat (2) @(posedge clk);
        #1;
        check("rst_imem_valid", {63'd0, mif.imem_req_valid}, 64'd0);
        check("rst_dmem_valid", {63'd0, mif.dmem_req_valid}, 64'd0);
        check("rst_retire",     {63'd0, retire},  64'd0);
        check("rst_halted",     {63'd0, halted},  64'd0);
        check("rst_illegal",    {63'd0, illegal}, 64'd0);
        check("rst_pc",         current_pc, RPC);
        rst = 1'b0;
        #1;
        wait_stop(100, edges);
        check("alu_halt_cycle", 64'(edges + 1), 64'd12);
        check("alu_halted", {63'd0, halted}, 64'd1);
        check("alu_pc", current_pc, RPC + 64'd8);
        idle(10);
        check("alu_x1", dut.rf_q[1], 64'd5);
        check("alu_x2", dut.rf_q[2], 64'd10);
        check("alu_retires", 64'(retire_n), 64'd3);
        check("alu_pc_frozen", current_pc, RPC + 64'd8);
        check("alu_no_req_after_halt", 64'(req_when_stopped), 64'd0);
        check("alu_illegal", {63'd0, illegal}, 64'd0);
`ifdef MULTICYCLE_CORE_PERF_CNT_EN
        check("perf_cycle", cycle_cnt, 64'd12);
        check("perf_instret", instret_cnt, 64'd3);
`else
        check("perf_cycle_off", cycle_cnt, 64'd0);
        check("perf_instret_off", instret_cnt, 64'd0);
`endif

        // First fetch stalled 3 cycles: addi x3,x0,7 ; ebreak
        clear_imem();
        imem[0] = 32'h0070_0193;
        imem[1] = EBREAK;
        mif.imem_req_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            check("stall_valid", {63'd0, mif.imem_req_valid}, 64'd1);
            check("stall_addr", mif.imem_addr, RPC);
            @(posedge clk);
            #1;
        end
        mif.imem_req_ready = 1'b1;
        wait_stop(100, edges);
        idle(3);
        check("stall_x3", dut.rf_q[3], 64'd7);
        check("stall_pc", current_pc, RPC + 64'd4);
        check("stall_retires", 64'(retire_n), 64'd2);
        check("stall_first_fetch", fetch_log[0], RPC);
        check("stall_fetches", 64'(fetch_n), 64'd2);

        // addi x5,x0,0x123 ; sd x5,16(x0) ; ld x6,16(x0) ; ebreak with 2-cycle load latency
        clear_imem();
        imem[0] = 32'h1230_0293;
        imem[1] = 32'h0050_3823;
        imem[2] = 32'h0100_3303;
        imem[3] = EBREAK;
        dmem_delay = 2;
        do_reset();
        wait_stop(200, edges);
        check("mem_halt_cycle", 64'(edges + 1), 64'd20);
        idle(3);
        check("mem_stores", 64'(st_n), 64'd1);
        check("mem_st_addr", st_addr, 64'd16);
        check("mem_st_wdata", st_wdata, 64'h123);
        check("mem_st_mask", {56'd0, st_mask}, 64'hFF);
        check("mem_x6", dut.rf_q[6], 64'h123);
        check("mem_pc", current_pc, RPC + 64'd12);
        check("mem_retires", 64'(retire_n), 64'd4);

        // jal x1,8 ; (ebreak at +4) ; jalr x0,1(x1) at +8
        clear_imem();
        imem[0] = 32'h0080_00EF;
        imem[1] = EBREAK;
        imem[2] = 32'h0010_8067;
        dmem_delay = 1;
        do_reset();
        wait_stop(100, edges);
        idle(3);
        check("jal_x1", dut.rf_q[1], RPC + 64'd4);
        check("jal_target", fetch_log[1], RPC + 64'd8);
        check("jalr_target", fetch_log[2], RPC + 64'd4);
        check("jump_pc", current_pc, RPC + 64'd4);
        check("jump_retires", 64'(retire_n), 64'd3);

        // lui x8,0x80000 ; auipc x9,1 ; sub x10,x9,x8 ; ebreak
        clear_imem();
        imem[0] = 32'h8000_0437;
        imem[1] = 32'h0000_1497;
        imem[2] = 32'h4084_8533;
        imem[3] = EBREAK;
        do_reset();
        wait_stop(100, edges);
        idle(3);
        check("lui_sext", dut.rf_q[8], 64'hFFFF_FFFF_8000_0000);
        check("auipc", dut.rf_q[9], 64'h0000_0000_8000_1004);
        check("sub_wrap", dut.rf_q[10], 64'h0000_0001_0000_1004);
        check("upper_pc", current_pc, RPC + 64'd12);

        // All-zero opcode traps; reset recovers
        clear_imem();
        do_reset();
        wait_stop(100, edges);
        idle(5);
        check("trap_illegal", {63'd0, illegal}, 64'd1);
        check("trap_halted", {63'd0, halted}, 64'd0);
        check("trap_retires", 64'(retire_n), 64'd0);
        check("trap_pc", current_pc, RPC);
        check("trap_fetches", 64'(fetch_n), 64'd1);
        check("trap_no_req", 64'(req_when_stopped), 64'd0);
`ifdef MULTICYCLE_CORE_PERF_CNT_EN
        check("trap_perf_cycle", cycle_cnt, 64'd4);
        check("trap_perf_instret", instret_cnt, 64'd0);
`endif
        do_reset();
        check("recover_illegal", {63'd0, illegal}, 64'd0);
        check("recover_valid", {63'd0, mif.imem_req_valid}, 64'd1);
        check("recover_addr", mif.imem_addr, RPC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
